// File: rtl/bufr_pkg.sv
// rtl/bufr_pkg.sv - shared constants and divide helpers for the regional clock buffer
package bufr_pkg;

   localparam int BUFR_MAX_DIVIDE = 8;
   localparam int BUFR_COUNT_W    = 4;

   typedef logic [BUFR_COUNT_W-1:0] bufr_count_t;

   // Output goes high once the half-period count reaches this value.
   function automatic bufr_count_t bufr_limit(int d);
      return (d == 1) ? bufr_count_t'(1) : bufr_count_t'(2 * ((d + 1) / 2));
   endfunction

   function automatic bufr_count_t bufr_wrap(int d);
      return bufr_count_t'(2 * d - 1);
   endfunction

endpackage

// File: rtl/bufr_edge_counter.sv
// rtl/bufr_edge_counter.sv - dual-edge modulo-(WRAP+1) half-period counter with async clear
module bufr_edge_counter
   import bufr_pkg::*;
#(
   parameter bufr_count_t WRAP = 4'd15
) (
   input  logic        clk,
   input  logic        clr_n,
   output bufr_count_t count
);

   // Registers hold the half-periods remaining (count = WRAP - stored), so a
   // zero power-up state reads as count WRAP and the first edge wraps to 0.
   bufr_count_t rise_q;
   bufr_count_t fall_q;

   function automatic bufr_count_t step_down(bufr_count_t v);
      return (v == '0) ? WRAP : v - bufr_count_t'(1);
   endfunction

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         rise_q <= WRAP;
      end else begin
         rise_q <= step_down(fall_q);
      end
   end

   always_ff @(negedge clk or negedge clr_n) begin
      if (!clr_n) begin
         fall_q <= WRAP;
      end else begin
         fall_q <= step_down(rise_q);
      end
   end

   // The register written by the most recent edge owns the current phase.
   assign count = WRAP - (clk ? rise_q : fall_q);

endmodule

// File: rtl/bufr_clk_div.sv
// rtl/bufr_clk_div.sv - regional clock buffer with optional divide; BUFR_PRIMITIVE_EN selects the vendor BUFR
module bufr_clk_div
   import bufr_pkg::*;
#(
   parameter BUFR_DIVIDE = "BYPASS"
) (
   input  logic I,
   input  logic CLR_N,
   input  logic CE,
   output logic O
);

   localparam logic [47:0] DIV_BITS  = 48'(BUFR_DIVIDE);
   localparam bit          IS_BYPASS = (DIV_BITS == "BYPASS");
   localparam bit          DIV_OK    = IS_BYPASS ||
                                       ((DIV_BITS >= 48'd1) && (DIV_BITS <= 48'(BUFR_MAX_DIVIDE)));
   localparam int          DIV       = IS_BYPASS ? 1 : int'(DIV_BITS[31:0]);

   generate
      if (!DIV_OK) begin : g_bad_divide
         $error("bufr_clk_div: BUFR_DIVIDE must be \"BYPASS\" or 1..8");
      end
   endgenerate

`ifdef BUFR_PRIMITIVE_EN
   BUFR #(
      .BUFR_DIVIDE (BUFR_DIVIDE)
   ) u_bufr (
      .I   (I),
      .CE  (CE),
      .CLR (~CLR_N),
      .O   (O)
   );
`else
   generate
      if (IS_BYPASS) begin : g_bypass
         logic unused_ctrl;
         assign unused_ctrl = CE ^ CLR_N;
         assign O = I;
      end else begin : g_divide
         localparam bufr_count_t WRAP  = bufr_wrap(DIV);
         localparam bufr_count_t LIMIT = bufr_limit(DIV);

         bufr_count_t count;

         bufr_edge_counter #(
            .WRAP (WRAP)
         ) u_cnt (
            .clk   (I),
            .clr_n (CLR_N),
            .count (count)
         );

         // CE gates only the output; the phase keeps advancing underneath.
         assign O = CE && (count >= LIMIT);
      end
   endgenerate
`endif

endmodule

// File: tb/tb_bufr_clk_div.sv
// tb/tb_bufr_clk_div.sv - directed vector bench for bufr_clk_div (bypass, /8, /3, /1)
module tb_bufr_clk_div;

   typedef struct packed {
      logic clr_n;
      logic ce8;
      logic exp8;
      logic exp3;
      logic exp1;
   } vec_t;

   logic clk   = 1'b0;
   logic clr_n = 1'b1;
   logic ce8   = 1'b1;
   logic ce3   = 1'b1;
   logic ce1   = 1'b1;
   logic ce_b  = 1'b0;
   logic clr_b = 1'b1;
   logic o8, o3, o1, o_b;

   int n_vec = 0;
   int n_err = 0;

   vec_t vecs [28];

   always #5 clk = ~clk;

   bufr_clk_div #(.BUFR_DIVIDE("BYPASS")) u_byp (.I(clk), .CLR_N(clr_b), .CE(ce_b), .O(o_b));
   bufr_clk_div #(.BUFR_DIVIDE(8))        u_d8  (.I(clk), .CLR_N(clr_n), .CE(ce8),  .O(o8));
   bufr_clk_div #(.BUFR_DIVIDE(3))        u_d3  (.I(clk), .CLR_N(clr_n), .CE(ce3),  .O(o3));
   bufr_clk_div #(.BUFR_DIVIDE(1))        u_d1  (.I(clk), .CLR_N(clr_n), .CE(ce1),  .O(o1));

   task automatic check(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: O=%b, want %b at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic edges(input int n);
      repeat (n) @(clk);
      #1;
   endtask

   initial begin
      // Fields: clr_n ce8 exp8 exp3 exp1; rows 2.. are edges 1..26 after clear release
      vecs = '{
         5'b01000, 5'b01000,
         5'b11001, 5'b11000, 5'b11001, 5'b11010, 5'b11011, 5'b11000, 5'b11001, 5'b11100,
         5'b11101, 5'b11110, 5'b11111, 5'b11100, 5'b11101, 5'b11100, 5'b11101, 5'b11010,
         5'b10011, 5'b10000, 5'b10001, 5'b10000, 5'b10001,
         5'b11010, 5'b11011, 5'b11100, 5'b11101, 5'b11100
      };

      #1;
      check("pwr_d8", o8, 1'b1);
      check("pwr_d3", o3, 1'b1);
      check("pwr_d1", o1, 1'b1);
      check("pwr_byp", o_b, clk);
      edges(1);
      check("pwr_edge1_d8", o8, 1'b0);
      check("pwr_edge1_d3", o3, 1'b0);
      check("pwr_edge1_d1", o1, 1'b0);

      for (int i = 0; i < 28; i++) begin
         clr_n = vecs[i].clr_n;
         ce8   = vecs[i].ce8;
         ce_b  = i[0];
         clr_b = i[1];
         #1;
         check($sformatf("vec%0d_byp_apply", i), o_b, clk);
         @(clk);
         #1;
         check($sformatf("vec%0d_d8", i), o8, vecs[i].exp8);
         check($sformatf("vec%0d_d3", i), o3, vecs[i].exp3);
         check($sformatf("vec%0d_d1", i), o1, vecs[i].exp1);
         check($sformatf("vec%0d_byp", i), o_b, clk);
      end

      // D=8 sits at count 10: dropping CE must take O low at once.
      ce8 = 1'b0;
      #1;
      check("ce_drop_now", o8, 1'b0);
      edges(6);
      check("ce_off_run", o8, 1'b0);
      ce8 = 1'b1;
      #1;
      check("ce_raise_cnt0", o8, 1'b0);
      edges(7);
      check("ce_on_cnt7", o8, 1'b0);
      edges(1);
      check("ce_on_cnt8", o8, 1'b1);
      edges(2);
      check("ce_on_cnt10", o8, 1'b1);

      clr_n = 1'b0;
      #1;
      check("clr_now", o8, 1'b0);
      for (int k = 0; k < 3; k++) begin
         edges(1);
         check($sformatf("clr_hold%0d", k), o8, 1'b0);
      end
      clr_n = 1'b1;
      edges(7);
      check("rel_edge7", o8, 1'b0);
      edges(1);
      check("rel_edge8", o8, 1'b1);
      edges(7);
      check("rel_edge15", o8, 1'b1);
      edges(1);
      check("rel_edge16", o8, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
